router_pkt_sink: RTL and testbench
==================================

// Module: router_pkt_sink
// PURPOSE
//  Downstream consumer for one router output port (data_out_N / vld_out_N / read_enb_N).
//  Waits a programmable delay after vld_out rises, then drains one packet: header, payload, parity.
//  Reports the length and address, checks parity and address, and counts packets.
//  Used as a bus-functional drain in system benches and as the front end of port-side logic.
// PARAMETERS
//  DATA_W      8   byte width; header = {len[DATA_W-1:2], addr[1:0]}
//  PORT_ID     0   expected addr field for this port (0..2)
//  START_DLY   2   cycles from vld_out rising to first read_enb; 0 = read on the next cycle
//  STALL_MAX   32  consecutive mid-packet cycles with vld_out low before abort
// PORTS
//  clock       in   1        rising-edge clock
//  reset       in   1        synchronous, active-high
//  enable      in   1        0 = never start a new packet; a packet already in progress completes
//  vld_out     in   1        router FIFO not empty
//  data_out    in   DATA_W   router FIFO data; valid 1 cycle after read_enb is sampled high
//  read_enb    out  1        FIFO read request
//  pkt_done    out  1        1-cycle pulse on the cycle the parity byte is captured, or on abort
//  pkt_len     out  DATA_W-2 captured payload length; held until the next header
//  pkt_addr    out  2        captured addr field
//  parity_err  out  1        with pkt_done: XOR(header, payload) != parity byte
//  addr_err    out  1        with pkt_done: pkt_addr != PORT_ID
//  trunc_err   out  1        with pkt_done: packet aborted by stall timeout
//  pkt_count   out  16       completed packets, including errored ones; wraps at 16'hFFFF->0
//  active      out  1        high in every state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters 0. Reset mid-packet drops the packet; no pkt_done.
//  FSM: IDLE -> DELAY when enable && vld_out; DELAY -> READ after START_DLY cycles
//       (IDLE -> READ directly if START_DLY=0); READ -> IDLE after the last byte is captured.
//  If vld_out falls during DELAY: return to IDLE with no outputs.
//  READ: read_enb = vld_out && (issued < total).
//   - total = 2 until the header is captured, then len+2.
//   - issued increments on each cycle with read_enb=1.
//   - Capture flag rd_q = read_enb delayed 1 cycle; each byte is taken when rd_q=1.
//  Byte 0 loads pkt_len and pkt_addr and seeds the XOR accumulator.
//  Bytes 1..len are XORed into the accumulator.
//  Byte len+1 is compared with the accumulator and fires pkt_done.
//  len=0 is legal (total=2): header then parity, no payload.
//  Stall: in READ with issued<total and vld_out=0, a stall counter increments; it clears when vld_out=1.
//   - At STALL_MAX: pkt_done=1, trunc_err=1, parity_err=0, go to IDLE. Bytes still in flight are discarded.
//  Error flags are valid only while pkt_done=1 and are 0 otherwise.
//  Back-to-back packets: from IDLE the next packet can start 1 cycle after pkt_done.
//  Minimum packet time with START_DLY=0: len+3 cycles from the first read_enb to pkt_done.
// CONFIGURATION
//  PKT_SINK_STATS_EN defined: adds output ports err_count[15:0] and byte_count[31:0].
//   - err_count: packets with any error flag set; saturates at 16'hFFFF.
//   - byte_count: captured bytes, wraps.
//   - Both are cleared by reset.
//  Undefined: these ports and their registers are absent; all other behaviour is identical.
// STRUCTURE
//  router_pkg: HDR_ADDR_W=2, header field slice functions, state enum {IDLE,DELAY,READ}.
//  Sub-module router_parity_acc: DATA_W XOR accumulator with load/accumulate/compare.
//  The FSM, counters and flags stay in router_pkt_sink.
// TESTING
//  1 PORT_ID=2; header 8'h16 (len 5, addr 2), 5 payload bytes, correct parity
//    -> 7 read_enb cycles, pkt_done with len 5, addr 2, all errors 0, pkt_count=1.
//  2 Same packet with the parity byte's bit 0 flipped -> pkt_done with parity_err=1; pkt_count increments.
//  3 PORT_ID=0; header 8'h3D (len 15, addr 1) -> addr_err=1 and the full 17 bytes are drained.
//  4 vld_out drops after 3 bytes and stays low 32 cycles -> pkt_done, trunc_err=1, back to IDLE.
//  5 START_DLY=2; vld_out high 1 cycle then low; later header 8'h00 (len 0) + parity 8'h00
//    -> no read on the glitch; then exactly 2 reads, pkt_done with len 0 and no errors.
//  6 reset asserted mid-payload -> read_enb=0 next cycle, no pkt_done, pkt_count=0;
//    enable=0 with vld_out=1 -> no reads.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and header-field helpers for the router port-side logic.
package router_pkg;

    localparam int unsigned HDR_ADDR_W = 2;
    localparam int unsigned HDR_W_MAX  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        READ  = 2'd2
    } state_t;

    // Header layout is {len, addr}; callers zero-extend the byte to HDR_W_MAX.
    function automatic logic [HDR_W_MAX-1:0] hdr_len_f(input logic [HDR_W_MAX-1:0] hdr);
        return hdr >> HDR_ADDR_W;
    endfunction

    function automatic logic [HDR_ADDR_W-1:0] hdr_addr_f(input logic [HDR_W_MAX-1:0] hdr);
        return hdr[HDR_ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/router_parity_acc.sv
// Byte-wide XOR accumulator: load seeds, acc folds in, match_c compares against data.
module router_parity_acc #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              acc,
    input  logic [DATA_W-1:0] data,
    output logic              match_c
);

    logic [DATA_W-1:0] value;

    always_ff @(posedge clock) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= data;
        end else if (acc) begin
            value <= value ^ data;
        end
    end

    assign match_c = (value == data);

endmodule

// File: rtl/router_pkt_sink.sv
// Drains one packet at a time from a router output port and reports length/address/errors.
// Optional PKT_SINK_STATS_EN adds err_count and byte_count statistics ports.
module router_pkt_sink
    import router_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned PORT_ID   = 0,
    parameter int unsigned START_DLY = 2,
    parameter int unsigned STALL_MAX = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              vld_out,
    input  logic [DATA_W-1:0] data_out,
    output logic              read_enb,
    output logic              pkt_done,
    output logic [DATA_W-3:0] pkt_len,
    output logic [1:0]        pkt_addr,
    output logic              parity_err,
    output logic              addr_err,
    output logic              trunc_err,
    output logic [15:0]       pkt_count,
    output logic              active
`ifdef PKT_SINK_STATS_EN
    ,
    output logic [15:0]       err_count,
    output logic [31:0]       byte_count
`endif
);

    localparam int unsigned LEN_W   = DATA_W - HDR_ADDR_W;
    localparam int unsigned CNT_W   = LEN_W + 1;
    localparam int unsigned DLY_W   = (START_DLY > 1) ? $clog2(START_DLY) : 1;
    localparam int unsigned STALL_W = $clog2(STALL_MAX + 1);

    state_t             state;
    logic [CNT_W-1:0]   issued;
    logic [CNT_W-1:0]   cap_cnt;
    logic               hdr_seen;
    logic               rd_q;
    logic [DLY_W-1:0]   dly_cnt;
    logic [STALL_W-1:0] stall_cnt;

    logic [CNT_W-1:0]   total_c;
    logic               stalling_c;
    logic               abort_c;
    logic               capture_c;
    logic               last_c;
    logic               addr_mis_c;
    logic               par_ok_c;

    // Until the header lands only header+parity are known to exist.
    assign total_c    = hdr_seen ? CNT_W'(pkt_len) + CNT_W'(2) : CNT_W'(2);
    assign read_enb   = (state == READ) && vld_out && (issued < total_c);
    assign stalling_c = (state == READ) && !vld_out && (issued < total_c);
    assign abort_c    = stalling_c && (stall_cnt == STALL_W'(STALL_MAX - 1));
    assign capture_c  = (state == READ) && rd_q && !abort_c;
    assign last_c     = hdr_seen && (cap_cnt == CNT_W'(pkt_len) + CNT_W'(1));
    assign addr_mis_c = hdr_seen && (pkt_addr != HDR_ADDR_W'(PORT_ID));

    router_parity_acc #(
        .DATA_W (DATA_W)
    ) u_parity_acc (
        .clock   (clock),
        .reset   (reset),
        .load    (capture_c && !hdr_seen),
        .acc     (capture_c && hdr_seen && !last_c),
        .data    (data_out),
        .match_c (par_ok_c)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            issued     <= '0;
            cap_cnt    <= '0;
            hdr_seen   <= 1'b0;
            rd_q       <= 1'b0;
            dly_cnt    <= '0;
            stall_cnt  <= '0;
            pkt_done   <= 1'b0;
            pkt_len    <= '0;
            pkt_addr   <= '0;
            parity_err <= 1'b0;
            addr_err   <= 1'b0;
            trunc_err  <= 1'b0;
            pkt_count  <= '0;
            active     <= 1'b0;
        end else begin
            rd_q       <= read_enb;
            pkt_done   <= 1'b0;
            parity_err <= 1'b0;
            addr_err   <= 1'b0;
            trunc_err  <= 1'b0;
            case (state)
                IDLE: begin
                    issued    <= '0;
                    cap_cnt   <= '0;
                    hdr_seen  <= 1'b0;
                    dly_cnt   <= '0;
                    stall_cnt <= '0;
                    if (enable && vld_out) begin
                        state  <= (START_DLY == 0) ? READ : DELAY;
                        active <= 1'b1;
                    end
                end
                DELAY: begin
                    if (!vld_out) begin
                        state  <= IDLE;
                        active <= 1'b0;
                    end else if (dly_cnt == DLY_W'(START_DLY - 1)) begin
                        state <= READ;
                    end else begin
                        dly_cnt <= dly_cnt + DLY_W'(1);
                    end
                end
                READ: begin
                    if (read_enb) begin
                        issued <= issued + CNT_W'(1);
                    end
                    if (vld_out) begin
                        stall_cnt <= '0;
                    end else if (stalling_c) begin
                        stall_cnt <= stall_cnt + STALL_W'(1);
                    end
                    if (abort_c) begin
                        pkt_done  <= 1'b1;
                        trunc_err <= 1'b1;
                        addr_err  <= addr_mis_c;
                        pkt_count <= pkt_count + 16'd1;
                        state     <= IDLE;
                        active    <= 1'b0;
                    end else if (capture_c) begin
                        cap_cnt <= cap_cnt + CNT_W'(1);
                        if (!hdr_seen) begin
                            hdr_seen <= 1'b1;
                            pkt_len  <= LEN_W'(hdr_len_f(HDR_W_MAX'(data_out)));
                            pkt_addr <= hdr_addr_f(HDR_W_MAX'(data_out));
                        end else if (last_c) begin
                            pkt_done   <= 1'b1;
                            parity_err <= !par_ok_c;
                            addr_err   <= addr_mis_c;
                            pkt_count  <= pkt_count + 16'd1;
                            state      <= IDLE;
                            active     <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    active <= 1'b0;
                end
            endcase
        end
    end

`ifdef PKT_SINK_STATS_EN
    // Statistics only observe the packet flow; they never feed back into it.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_count  <= '0;
            byte_count <= '0;
        end else begin
            if (capture_c) begin
                byte_count <= byte_count + 32'd1;
            end
            if ((abort_c || (capture_c && last_c && (!par_ok_c || addr_mis_c)))
                && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_router_pkt_sink.sv
// Directed and randomized bench for router_pkt_sink with a queue-based router FIFO model.
module tb_router_pkt_sink;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned PORT_ID   = 2;
    localparam int unsigned START_DLY = 2;
    localparam int unsigned STALL_MAX = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic              enable;
    logic              vld_out;
    logic [DATA_W-1:0] data_out;
    logic              read_enb;
    logic              pkt_done;
    logic [DATA_W-3:0] pkt_len;
    logic [1:0]        pkt_addr;
    logic              parity_err;
    logic              addr_err;
    logic              trunc_err;
    logic [15:0]       pkt_count;
    logic              active;
`ifdef PKT_SINK_STATS_EN
    logic [15:0]       err_count;
    logic [31:0]       byte_count;
`endif

    router_pkt_sink #(
        .DATA_W    (DATA_W),
        .PORT_ID   (PORT_ID),
        .START_DLY (START_DLY),
        .STALL_MAX (STALL_MAX)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .vld_out    (vld_out),
        .data_out   (data_out),
        .read_enb   (read_enb),
        .pkt_done   (pkt_done),
        .pkt_len    (pkt_len),
        .pkt_addr   (pkt_addr),
        .parity_err (parity_err),
        .addr_err   (addr_err),
        .trunc_err  (trunc_err),
        .pkt_count  (pkt_count),
        .active     (active)
`ifdef PKT_SINK_STATS_EN
        ,
        .err_count  (err_count),
        .byte_count (byte_count)
`endif
    );

    always #5 clock = ~clock;

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    logic [7:0]  fifo[$];
    bit          gate;

    int          rd_cnt, first_rd, last_rd, done_cyc;
    bit          done_seen, flag_leak, rd_now;
    logic [5:0]  d_len;
    logic [1:0]  d_addr;
    logic        d_perr, d_aerr, d_terr, d_active;
    logic [15:0] d_cnt;

    logic [15:0] exp_count;
    int          e_len, e_addr;
    bit          e_perr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic update_vld();
        vld_out = gate && (fifo.size() != 0);
    endtask

    task automatic clear_mon();
        rd_cnt    = 0;
        first_rd  = -1;
        last_rd   = -1;
        done_cyc  = -1;
        done_seen = 1'b0;
        flag_leak = 1'b0;
    endtask

    // Observe one cycle mid-period, then act as the router FIFO just after the edge.
    task automatic step();
        @(negedge clock);
        cyc++;
        rd_now = read_enb;
        if (read_enb) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
        end
        if (pkt_done) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
            d_len     = pkt_len;
            d_addr    = pkt_addr;
            d_perr    = parity_err;
            d_aerr    = addr_err;
            d_terr    = trunc_err;
            d_cnt     = pkt_count;
            d_active  = active;
        end else if (parity_err || addr_err || trunc_err) begin
            flag_leak = 1'b1;
        end
        @(posedge clock);
        #1;
        if (rd_now && fifo.size() != 0) data_out = fifo.pop_front();
        update_vld();
    endtask

    // Queue a well-formed packet; expected results come from the packet contents.
    task automatic push_pkt(input int len, input int addr, input bit corrupt);
        logic [7:0] hdr, par, b;
        hdr = 8'((len << 2) | (addr & 3));
        par = hdr;
        fifo.push_back(hdr);
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            par ^= b;
            fifo.push_back(b);
        end
        if (corrupt) par ^= 8'(1 << $urandom_range(0, 7));
        fifo.push_back(par);
        e_len  = len;
        e_addr = addr;
        e_perr = corrupt;
        update_vld();
    endtask

    task automatic finish_pkt(input string tag, input bit stall_en);
        int n = 0;
        int stall_left = 0;
        bit stalled = 1'b0;
        clear_mon();
        while (!done_seen && n < 400) begin
            if (stall_en) begin
                if (stall_left > 0) stall_left--;
                else if ($urandom_range(0, 9) == 0) stall_left = $urandom_range(1, 5);
                gate = (stall_left == 0);
                if (!gate) stalled = 1'b1;
            end
            step();
            n++;
        end
        gate = 1'b1;
        update_vld();
        exp_count = exp_count + 16'd1;
        check({tag, ".done"}, 32'(done_seen), 32'd1);
        check({tag, ".len"}, 32'(d_len), 32'(e_len));
        check({tag, ".addr"}, 32'(d_addr), 32'(e_addr));
        check({tag, ".perr"}, 32'(d_perr), 32'(e_perr));
        check({tag, ".aerr"}, 32'(d_aerr), 32'(e_addr != int'(PORT_ID)));
        check({tag, ".terr"}, 32'(d_terr), 32'd0);
        check({tag, ".count"}, 32'(d_cnt), 32'(exp_count));
        check({tag, ".reads"}, 32'(rd_cnt), 32'(e_len + 2));
        check({tag, ".leak"}, 32'(flag_leak), 32'd0);
        check({tag, ".active"}, 32'(d_active), 32'd0);
        check({tag, ".drained"}, 32'(fifo.size()), 32'd0);
        if (!stalled) check({tag, ".latency"}, 32'(done_cyc - first_rd), 32'(e_len + 3));
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b1;
        vld_out   = 1'b0;
        data_out  = '0;
        gate      = 1'b1;
        exp_count = '0;
        clear_mon();
        repeat (3) step();
        check("rst.read_enb", 32'(read_enb), 32'd0);
        check("rst.pkt_done", 32'(pkt_done), 32'd0);
        check("rst.pkt_len", 32'(pkt_len), 32'd0);
        check("rst.pkt_count", 32'(pkt_count), 32'd0);
        check("rst.active", 32'(active), 32'd0);
        reset = 1'b0;
        step();

        // Header 0x16: len 5 addr 2, good parity.
        push_pkt(5, 2, 1'b0);
        finish_pkt("t1", 1'b0);

        push_pkt(5, 2, 1'b1);
        finish_pkt("t2", 1'b0);

        // Header 0x3D: len 15 addr 1 -> address error, full drain.
        push_pkt(15, 1, 1'b0);
        finish_pkt("t3", 1'b0);

        // Truncation: header promises 10 bytes, only 2 arrive.
        fifo.push_back(8'((10 << 2) | 2));
        fifo.push_back(8'hA5);
        fifo.push_back(8'h3C);
        update_vld();
        clear_mon();
        for (int n = 0; n < 200 && !done_seen; n++) step();
        exp_count = exp_count + 16'd1;
        check("t4.done", 32'(done_seen), 32'd1);
        check("t4.terr", 32'(d_terr), 32'd1);
        check("t4.perr", 32'(d_perr), 32'd0);
        check("t4.reads", 32'(rd_cnt), 32'd3);
        check("t4.gap", 32'(done_cyc - last_rd), 32'(STALL_MAX + 1));
        check("t4.count", 32'(d_cnt), 32'(exp_count));
        check("t4.active", 32'(d_active), 32'd0);

        // One-cycle vld glitch during the start delay, then a len-0 packet.
        push_pkt(0, 2, 1'b0);
        clear_mon();
        gate = 1'b0;
        repeat (10) step();
        check("t5.glitch_reads", 32'(rd_cnt), 32'd0);
        check("t5.glitch_active", 32'(active), 32'd0);
        gate = 1'b1;
        update_vld();
        finish_pkt("t5", 1'b0);

        for (int k = 0; k < 25; k++) begin
            push_pkt($urandom_range(0, 20), $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
            finish_pkt($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)));
        end

        // Reset mid-payload drops the packet; then enable=0 blocks a new start.
        push_pkt(12, 2, 1'b0);
        clear_mon();
        repeat (7) step();
        check("t6.mid_reads", 32'(rd_cnt > 0), 32'd1);
        reset = 1'b1;
        step();
        reset  = 1'b0;
        enable = 1'b0;
        step();
        check("t6.read_enb", 32'(rd_now), 32'd0);
        check("t6.no_done", 32'(done_seen), 32'd0);
        check("t6.count", 32'(pkt_count), 32'd0);
        check("t6.active", 32'(active), 32'd0);
        exp_count = '0;
        fifo.delete();
        push_pkt(4, 2, 1'b0);
        clear_mon();
        repeat (20) step();
        check("t6.disabled_reads", 32'(rd_cnt), 32'd0);
        check("t6.disabled_active", 32'(active), 32'd0);
        enable = 1'b1;
        finish_pkt("t6.after", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
